pe_lane_mac: RTL and testbench
==============================

# pe_lane_mac

Parametrised multi-lane processing element for the dense-layer datapath. Computes one output neuron, `result = act(sat(sum(in[i]*w[i]) + bias))`, consuming LANES element pairs per cycle instead of one. It generalises the single-lane sequential PE with lane parallelism, an explicit busy/done handshake, a selectable ReLU and output saturation with a flag. Instances sit in a row inside the layer controller, one per weight row.

## Interface
- VECTOR_LENGTH, 16: elements per dot product; must be a multiple of LANES.
- W, 8: signed width of each input, weight and bias element.
- LANES, 4: multiply-accumulates per cycle; 1 ≤ LANES ≤ VECTOR_LENGTH.
- ACC_WIDTH, 2*W+$clog2(VECTOR_LENGTH)+1: accumulator width (21 at defaults). Guaranteed overflow-free.
- OUT_WIDTH, 2*W: signed result width; must be ≤ ACC_WIDTH.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only in IDLE or DONE.
- relu_en  in  1  captured at the accepted start.
- in_vector_flat  in  W*VECTOR_LENGTH  signed elements; element i is at [i*W +: W].
- weight_row_flat  in  W*VECTOR_LENGTH  signed weights, same packing.
- bias  in  W  signed; captured at the accepted start.
- result  out  OUT_WIDTH  signed; holds its value until the next accepted start.
- sat  out  1  high when result was clamped; valid with done.
- busy  out  1  high in ACCUM and FINAL.
- done  out  1  level; high from completion until the next accepted start.

## Operation
- States: IDLE, ACCUM, FINAL, DONE. On reset: IDLE; result=0, sat=0, busy=0, done=0, acc=0, chunk=0.
- IDLE/DONE + start → ACCUM:
  - acc←0, chunk←0, done←0, sat←0.
  - Capture bias and relu_en.
  - result keeps its old value until FINAL overwrites it.
- ACCUM, each cycle:
  - Multiply elements chunk*LANES .. chunk*LANES+LANES-1 of both vectors, sign-extended to ACC_WIDTH.
  - Reduce the products with an adder tree and add the sum to acc.
  - chunk increments. After chunk N-1 (N = VECTOR_LENGTH/LANES) → FINAL.
- FINAL:
  - s = acc + sign-extended bias.
  - If relu_en and s<0, s = 0.
  - Clamp s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. sat=1 iff a clamp occurred.
  - Register result and sat, done←1, go to DONE.
- start in ACCUM or FINAL is ignored; the computation in progress is unaffected.
- in_vector_flat and weight_row_flat are sampled live. The caller holds them stable from the start cycle until done.
- A start in DONE restarts immediately; done drops on that edge.
- reset in any state aborts and wins over start in the same cycle.

## Timing
- start sampled at edge T. ACCUM occupies edges T+1..T+N, FINAL is edge T+N+1, and done and result are visible after edge T+N+1.
- Latency is N+1 cycles: 5 at defaults, 17 for LANES=1.
- busy is high for exactly N+1 cycles. Back-to-back throughput is one result per N+2 cycles (start asserted while done).
- Each adder tree has ceil(log2 LANES) levels and is purely combinational within ACCUM. No extra pipeline stage is allowed.

## Structure
- Package pe_pkg: state enum (IDLE, ACCUM, FINAL, DONE) and a sign-extend function parametrised by widths.
- Sub-module pe_lane_dot: combinational LANES-wide signed multiply plus adder tree, producing an ACC_WIDTH sum.
- Top level: FSM, chunk counter, accumulator, and the bias/ReLU/saturation stage.

## Test plan
All cases at default parameters.
- Basic: in all 1, w all 1, bias=3, relu_en=0 → result=19, sat=0. done rises 5 cycles after start; busy is high for 5 cycles.
- Signed: in[i]=i-8, w all -1, bias=-2 → result=6. Same vectors with w all 1 and relu_en=1 → result=0, sat=0.
- Saturation: in all -128, w all -128, bias=0 → result=32767, sat=1. in all -128, w all 127 → result=-32768, sat=1.
- Handshake:
  - start pulsed again at cycle 2 of busy → ignored; first result intact.
  - start held high across done → next computation begins on the done cycle; done drops on that edge.
- Reset mid-operation: reset at ACCUM cycle 2 → all outputs 0 next edge, state IDLE. A fresh start then yields a correct result.
- Sweep: LANES ∈ {1,2,16} with random vectors → result matches a reference model, latency = VECTOR_LENGTH/LANES+1.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the lane-parallel dense-layer processing element.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } pe_state_t;

  localparam int unsigned SEXT_W = 64;

  // Treats bit from_w-1 of v as the sign and replicates it up to SEXT_W bits.
  function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                                    input int unsigned       from_w);
    logic signed [SEXT_W-1:0] t;
    t = v << (SEXT_W - from_w);
    return t >>> (SEXT_W - from_w);
  endfunction

endpackage

// File: rtl/pe_lane_dot.sv
// Combinational LANES-wide signed multiply followed by a balanced adder tree.
module pe_lane_dot
  import pe_pkg::*;
#(
  parameter int W         = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 21
) (
  input  logic [LANES*W-1:0]          i_a_flat,
  input  logic [LANES*W-1:0]          i_b_flat,
  output logic signed [ACC_WIDTH-1:0] o_sum
);

  // Leaves are padded to a power of two so every tree level halves cleanly.
  localparam int LV = $clog2(LANES);
  localparam int P  = 1 << LV;

  always_comb begin
    logic signed [ACC_WIDTH-1:0] v [P];
    logic signed [2*W-1:0]       a2;
    logic signed [2*W-1:0]       b2;
    logic signed [2*W-1:0]       p;
    a2 = '0;
    b2 = '0;
    p  = '0;
    for (int i = 0; i < P; i++) begin
      v[i] = '0;
      if (i < LANES) begin
        a2   = (2*W)'($signed(i_a_flat[i*W +: W]));
        b2   = (2*W)'($signed(i_b_flat[i*W +: W]));
        p    = a2 * b2;
        v[i] = ACC_WIDTH'(sext(64'(unsigned'(p)), 2*W));
      end
    end
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < (P >> (l + 1)); i++) begin
        v[i] = v[2*i] + v[2*i+1];
      end
    end
    o_sum = v[0];
  end

endmodule

// File: rtl/pe_lane_mac.sv
// Multi-lane dot-product PE: accumulates LANES products per cycle, then adds bias, applies optional ReLU and saturates.
module pe_lane_mac
  import pe_pkg::*;
#(
  parameter int VECTOR_LENGTH = 16,
  parameter int W             = 8,
  parameter int LANES         = 4,
  parameter int ACC_WIDTH     = 2*W + $clog2(VECTOR_LENGTH) + 1,
  parameter int OUT_WIDTH     = 2*W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          relu_en,
  input  logic [W*VECTOR_LENGTH-1:0]    in_vector_flat,
  input  logic [W*VECTOR_LENGTH-1:0]    weight_row_flat,
  input  logic signed [W-1:0]           bias,
  output logic signed [OUT_WIDTH-1:0]   result,
  output logic                          sat,
  output logic                          busy,
  output logic                          done
);

  localparam int N  = VECTOR_LENGTH / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic signed [ACC_WIDTH:0] MAXV =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

  pe_state_t                    r_state;
  logic [CW-1:0]                r_chunk;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [W-1:0]          r_bias;
  logic                         r_relu;

  int                           w_base;
  logic [LANES*W-1:0]           w_in_chunk;
  logic [LANES*W-1:0]           w_wt_chunk;
  logic signed [ACC_WIDTH-1:0]  w_dot;
  logic signed [ACC_WIDTH:0]    w_fin;
  logic signed [ACC_WIDTH:0]    w_act;
  logic [OUT_WIDTH:0]           w_clamp;

  // Returns {clamped_flag, value} with value limited to the OUT_WIDTH signed range.
  function automatic logic [OUT_WIDTH:0] f_clamp(input logic signed [ACC_WIDTH:0] s);
    if (s > MAXV) return {1'b1, OUT_WIDTH'(MAXV)};
    if (s < MINV) return {1'b1, OUT_WIDTH'(MINV)};
    return {1'b0, OUT_WIDTH'(s)};
  endfunction

  function automatic logic signed [ACC_WIDTH:0] f_relu(input logic signed [ACC_WIDTH:0] s,
                                                       input logic                    en);
    return (en && (s < 0)) ? '0 : s;
  endfunction

  // ACCUM stage: live slice of both vectors selected by the chunk counter
  assign w_base     = int'(r_chunk) * LANES * W;
  assign w_in_chunk = in_vector_flat[w_base +: LANES*W];
  assign w_wt_chunk = weight_row_flat[w_base +: LANES*W];

  pe_lane_dot #(
    .W         (W),
    .LANES     (LANES),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_dot (
    .i_a_flat (w_in_chunk),
    .i_b_flat (w_wt_chunk),
    .o_sum    (w_dot)
  );

  // FINAL stage: bias add one bit wider than the accumulator, then ReLU and clamp
  assign w_fin = (ACC_WIDTH+1)'(sext(64'(unsigned'(r_acc)), ACC_WIDTH))
               + (ACC_WIDTH+1)'(sext(64'(unsigned'(r_bias)), W));
  assign w_act   = f_relu(w_fin, r_relu);
  assign w_clamp = f_clamp(w_act);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_chunk <= '0;
      r_acc   <= '0;
      r_bias  <= '0;
      r_relu  <= 1'b0;
      result  <= '0;
      sat     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_acc   <= '0;
            r_chunk <= '0;
            r_bias  <= bias;
            r_relu  <= relu_en;
            sat     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc <= r_acc + w_dot;
          if (r_chunk == LAST) begin
            r_chunk <= '0;
            r_state <= FINAL;
          end else begin
            r_chunk <= r_chunk + 1'b1;
          end
        end
        FINAL: begin
          result  <= w_clamp[OUT_WIDTH-1:0];
          sat     <= w_clamp[OUT_WIDTH];
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_lane_mac.sv
// Bench for pe_lane_mac: four lane widths share one stimulus and are checked every cycle against a behavioural model.
module tb_pe_lane_mac;

  localparam int VL = 16;
  localparam int W  = 8;
  localparam int NI = 4;

  function automatic int lanes_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 16;
    endcase
  endfunction

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 relu_en;
  logic [W*VL-1:0]      in_flat;
  logic [W*VL-1:0]      w_flat;
  logic signed [W-1:0]  bias;
  logic signed [15:0]   res_o  [NI];
  logic                 sat_o  [NI];
  logic                 busy_o [NI];
  logic                 done_o [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    pe_lane_mac #(
      .VECTOR_LENGTH (VL),
      .W             (W),
      .LANES         (lanes_of(k))
    ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .relu_en         (relu_en),
      .in_vector_flat  (in_flat),
      .weight_row_flat (w_flat),
      .bias            (bias),
      .result          (res_o[k]),
      .sat             (sat_o[k]),
      .busy            (busy_o[k]),
      .done            (done_o[k])
    );
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int k,
                     input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[lanes=%0d] got %0d want %0d at %0t", nm, lanes_of(k), act, exp, $time);
    end
  endtask

  // Reference: plain integer dot product, bias, ReLU and 16-bit clamp.
  task automatic ref_calc(output int r, output bit s);
    longint acc;
    int a, b;
    acc = 0;
    for (int i = 0; i < VL; i++) begin
      a = $signed(in_flat[i*W +: W]);
      b = $signed(w_flat[i*W +: W]);
      acc += longint'(a * b);
    end
    acc += longint'(int'(bias));
    if (relu_en && acc < 0) acc = 0;
    s = 1'b0;
    if (acc > 32767)       begin acc = 32767;  s = 1'b1; end
    else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    r = int'(acc);
  endtask

  // Model: an accepted start fixes the answer and a countdown of N+1 cycles.
  int cnt    [NI];
  int m_res  [NI];
  bit m_sat  [NI];
  bit m_busy [NI];
  bit m_done [NI];
  int p_res  [NI];
  bit p_sat  [NI];

  initial begin
    for (int k = 0; k < NI; k++) begin
      cnt[k] = 0; m_res[k] = 0; m_sat[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
        if (reset) begin
          cnt[k] = 0; m_res[k] = 0; m_sat[k] = 0; m_busy[k] = 0; m_done[k] = 0;
        end else if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) begin
            m_busy[k] = 0;
            m_done[k] = 1;
            m_res[k]  = p_res[k];
            m_sat[k]  = p_sat[k];
          end
        end else if (start) begin
          ref_calc(p_res[k], p_sat[k]);
          cnt[k]    = VL / lanes_of(k) + 1;
          m_busy[k] = 1;
          m_done[k] = 0;
          m_sat[k]  = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < NI; k++) begin
          chk("busy",   k, 32'(busy_o[k]), 32'(m_busy[k]));
          chk("done",   k, 32'(done_o[k]), 32'(m_done[k]));
          chk("result", k, res_o[k],       m_res[k]);
          chk("sat",    k, 32'(sat_o[k]),  32'(m_sat[k]));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic bit any_busy();
    bit b = 0;
    for (int k = 0; k < NI; k++) b |= (busy_o[k] !== 1'b0);
    return b;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (any_busy() && t < 100) begin
      tick();
      t++;
    end
    if (any_busy()) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout got busy want idle at %0t", $time);
    end
  endtask

  int lat  [NI];
  int bcnt [NI];

  // Starts all instances and records start-to-done latency and busy cycles.
  task automatic run_measure();
    int cyc = 0;
    for (int k = 0; k < NI; k++) begin lat[k] = -1; bcnt[k] = 0; end
    pulse_start();
    while (any_busy() && cyc < 40) begin
      for (int k = 0; k < NI; k++) if (busy_o[k] === 1'b1) bcnt[k]++;
      tick();
      cyc++;
      for (int k = 0; k < NI; k++) if (lat[k] < 0 && done_o[k] === 1'b1) lat[k] = cyc;
    end
  endtask

  task automatic set_fill(input int a, input int b);
    for (int i = 0; i < VL; i++) begin
      in_flat[i*W +: W] = W'(a);
      w_flat[i*W +: W]  = W'(b);
    end
  endtask

  task automatic expect_all(input string nm, input int r, input int s);
    for (int k = 0; k < NI; k++) begin
      chk({nm, "_res"}, k, res_o[k], r);
      chk({nm, "_sat"}, k, 32'(sat_o[k]), s);
    end
  endtask

  int exp_r;
  bit exp_s;
  int gap;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    relu_en = 1'b0;
    bias    = '0;
    in_flat = '0;
    w_flat  = '0;
    tick(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_result", k, res_o[k], 0);
      chk("rst_busy",   k, 32'(busy_o[k]), 0);
      chk("rst_done",   k, 32'(done_o[k]), 0);
    end

    // Basic: all ones, bias 3
    set_fill(1, 1);
    bias = 8'sd3;
    run_measure();
    expect_all("basic", 19, 0);
    for (int k = 0; k < NI; k++) begin
      chk("latency",  k, lat[k],  VL / lanes_of(k) + 1);
      chk("busy_len", k, bcnt[k], VL / lanes_of(k) + 1);
    end
    chk("latency_l4", 0, lat[0], 5);
    chk("latency_l1", 1, lat[1], 17);

    // Signed: in[i]=i-8
    for (int i = 0; i < VL; i++) begin
      in_flat[i*W +: W] = W'(i - 8);
      w_flat[i*W +: W]  = 8'hFF;
    end
    bias = -8'sd2;
    pulse_start();
    wait_idle();
    expect_all("signed", 6, 0);
    for (int i = 0; i < VL; i++) w_flat[i*W +: W] = 8'h01;
    relu_en = 1'b1;
    pulse_start();
    wait_idle();
    expect_all("relu", 0, 0);
    relu_en = 1'b0;

    // Saturation both directions
    set_fill(-128, -128);
    bias = 8'sd0;
    pulse_start();
    wait_idle();
    expect_all("sat_pos", 32767, 1);
    set_fill(-128, 127);
    pulse_start();
    wait_idle();
    expect_all("sat_neg", -32768, 1);

    // Start during busy is ignored even with a different bias presented
    in_flat = {$urandom, $urandom, $urandom, $urandom};
    w_flat  = {$urandom, $urandom, $urandom, $urandom};
    bias    = 8'sd5;
    ref_calc(exp_r, exp_s);
    pulse_start();
    tick();
    bias = -8'sd100;
    pulse_start();
    wait_idle();
    expect_all("ignore", exp_r, 32'(exp_s));

    // Start held high across done restarts on the done cycle
    start = 1'b1;
    gap = 0;
    while (done_o[0] !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
    chk("held_done", 0, 32'(done_o[0]), 1);
    tick();
    chk("held_drop", 0, 32'(done_o[0]), 0);
    chk("held_busy", 0, 32'(busy_o[0]), 1);
    tick(8);
    start = 1'b0;
    wait_idle();

    // Reset during the second ACCUM cycle
    pulse_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("mid_rst_result", k, res_o[k], 0);
      chk("mid_rst_busy",   k, 32'(busy_o[k]), 0);
      chk("mid_rst_done",   k, 32'(done_o[k]), 0);
      chk("mid_rst_sat",    k, 32'(sat_o[k]), 0);
    end
    set_fill(2, -3);
    bias = 8'sd7;
    pulse_start();
    wait_idle();
    expect_all("after_rst", -89, 0);

    // Randomised sweep with occasional extremes and stray starts
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0:       set_fill(-128, $urandom_range(0, 1) ? -128 : 127);
        1:       set_fill(127, 127);
        default: begin
          in_flat = {$urandom, $urandom, $urandom, $urandom};
          w_flat  = {$urandom, $urandom, $urandom, $urandom};
        end
      endcase
      bias    = W'($urandom);
      relu_en = 1'($urandom);
      pulse_start();
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(0, 3));
        pulse_start();
      end
      wait_idle();
      tick($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
